mandel_pixel_scheduler: RTL and testbench

- Sequences a full-frame Mandelbrot render by walking the SCREEN_W x SCREEN_H pixel raster.
- For each pixel, computes the complex coordinate (cx, cy) in signed Q10.22 and dispatches it to one of NUM_ENG iteration engines.
- Collects engine results through a round-robin arbiter and converts each into one VGA plot with pixel coordinates and colour.
- Sits between the top-level start/done control and the engine array, and owns the single VGA plot port.

---
 rtl/mandel_pkg.sv | 17 +
 rtl/mandel_pixel_scheduler_if.sv | 23 ++
 rtl/rr_arbiter.sv | 26 ++
 rtl/mandel_pixel_scheduler.sv | 155 +++++++++++++++
 tb/tb_mandel_pixel_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// Shared types, defaults and the colour mapping for the Mandelbrot pixel scheduler.
package mandel_pkg;

    typedef logic signed [31:0] fixed_t;

    localparam int unsigned FRAC_BITS    = 22;
    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // Points that never escape are painted black; others cycle through 8 colours.
    function automatic logic [2:0] colour_of(input logic [31:0] iter, input logic [31:0] max_iter);
        colour_of = (iter == max_iter) ? 3'b000 : iter[2:0];
    endfunction

endpackage

// File: rtl/mandel_pixel_scheduler_if.sv
// Engine-array bus: dispatch pulses with a shared coordinate bus, and result handshake.
interface mandel_pixel_scheduler_if #(
    parameter int unsigned NUM_ENG = 4,
    parameter int unsigned ITER_W  = 8
);
    logic [NUM_ENG-1:0]        eng_start;
    mandel_pkg::fixed_t        eng_cx;
    mandel_pkg::fixed_t        eng_cy;
    logic [NUM_ENG-1:0]        eng_idle;
    logic [NUM_ENG-1:0]        eng_res_valid;
    logic [NUM_ENG*ITER_W-1:0] eng_res_iter;
    logic [NUM_ENG-1:0]        eng_res_ack;

    modport master (
        output eng_start, eng_cx, eng_cy, eng_res_ack,
        input  eng_idle, eng_res_valid, eng_res_iter
    );

    modport slave (
        input  eng_start, eng_cx, eng_cy, eng_res_ack,
        output eng_idle, eng_res_valid, eng_res_iter
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    grant
);
    int unsigned idx;
    logic        found;

    // Scan upward from ptr with wrap-around; first requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Walks the pixel raster, dispatches coordinates to idle engines and turns results into plots.
module mandel_pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int unsigned NUM_ENG  = 4,
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF,
    parameter int unsigned ITER_W   = 8,
    parameter int unsigned MAX_ITER = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  fixed_t                          xmin,
    input  fixed_t                          ymax,
    input  fixed_t                          dx,
    input  fixed_t                          dy,
    output logic                            done,
    mandel_pixel_scheduler_if.master        eng,
    output logic [8:0]                      vga_x,
    output logic [7:0]                      vga_y,
    output logic [2:0]                      vga_colour,
    output logic                            vga_plot
);
    localparam int unsigned PtrW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    state_t             state_q, state_d;
    fixed_t             xmin_q, ymax_q, dx_q, dy_q;
    fixed_t             cur_cx_q, cur_cy_q, hold_cx_q, hold_cy_q;
    logic [8:0]         x_q;
    logic [7:0]         y_q;
    logic [NUM_ENG-1:0] busy_q, ack_q, disp, req, grant;
    logic [16:0]        tag_q [NUM_ENG];
    logic [PtrW-1:0]    ptr_q, grant_idx;
    logic [2:0]         grant_colour;
    logic               dispatching, grant_any, eol, last_pixel, arb_en, can_start;

    assign eol         = (x_q == 9'(SCREEN_W - 1));
    assign last_pixel  = eol && (y_q == 8'(SCREEN_H - 1));
    assign dispatching = |disp;
    assign grant_any   = |grant;
    assign can_start   = (state_q == IDLE || state_q == DONE) && start;
    // An engine being acked this cycle is still busy, so it cannot be re-granted.
    assign arb_en      = (state_q == RUN || state_q == DRAIN) && !rst;
    assign req         = arb_en ? (busy_q & eng.eng_res_valid & ~ack_q) : '0;

    assign eng.eng_start   = disp;
    assign eng.eng_cx      = dispatching ? cur_cx_q : hold_cx_q;
    assign eng.eng_cy      = dispatching ? cur_cy_q : hold_cy_q;
    assign eng.eng_res_ack = ack_q;
    assign done            = (state_q == DONE);

    rr_arbiter #(
        .N    (NUM_ENG),
        .PtrW (PtrW)
    ) u_res_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant)
    );

    // Pick the lowest-index engine that is idle and not waiting on a result.
    always_comb begin
        disp = '0;
        if (state_q == RUN && !rst) begin
            for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
                if (eng.eng_idle[i] && !busy_q[i]) begin
                    disp    = '0;
                    disp[i] = 1'b1;
                end
            end
        end
    end

    // Encode the granted engine and map its iteration count to a colour.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            if (grant[i]) grant_idx = PtrW'(i);
        end
        grant_colour = colour_of(32'(eng.eng_res_iter[grant_idx*ITER_W +: ITER_W]),
                                 32'(MAX_ITER));
    end

    // Frame sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (dispatching && last_pixel) state_d = DRAIN;
            DRAIN:      if (busy_q == '0 && !vga_plot) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // State, raster walk, engine bookkeeping and the registered plot port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            xmin_q     <= '0;
            ymax_q     <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            cur_cx_q   <= '0;
            cur_cy_q   <= '0;
            hold_cx_q  <= '0;
            hold_cy_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            busy_q     <= '0;
            ack_q      <= '0;
            ptr_q      <= '0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            for (int unsigned i = 0; i < NUM_ENG; i++) tag_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= grant;
            vga_plot <= grant_any;
            busy_q   <= (busy_q & ~ack_q) | disp;
            if (grant_any) begin
                {vga_x, vga_y} <= tag_q[grant_idx];
                vga_colour     <= grant_colour;
                ptr_q          <= PtrW'((32'(grant_idx) + 32'd1) % NUM_ENG);
            end
            if (can_start) begin
                xmin_q   <= xmin;
                ymax_q   <= ymax;
                dx_q     <= dx;
                dy_q     <= dy;
                cur_cx_q <= xmin;
                cur_cy_q <= ymax;
                x_q      <= '0;
                y_q      <= '0;
            end else if (dispatching) begin
                hold_cx_q <= cur_cx_q;
                hold_cy_q <= cur_cy_q;
                for (int unsigned i = 0; i < NUM_ENG; i++) begin
                    if (disp[i]) tag_q[i] <= {x_q, y_q};
                end
                if (eol) begin
                    x_q      <= '0;
                    cur_cx_q <= xmin_q;
                    y_q      <= y_q + 8'd1;
                    cur_cy_q <= cur_cy_q - dy_q;
                end else begin
                    x_q      <= x_q + 9'd1;
                    cur_cx_q <= cur_cx_q + dx_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Directed bench: a 2x2 single-engine instance for raster order, a default instance for the rest.
module tb_mandel_pixel_scheduler;
    import mandel_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default-size instance (4 engines, 160x120)
    logic       f_start = 1'b0;
    fixed_t     f_xmin = '0, f_ymax = '0, f_dx = '0, f_dy = '0;
    logic       f_done, f_plot;
    logic [8:0] f_vx;
    logic [7:0] f_vy;
    logic [2:0] f_vc;
    mandel_pixel_scheduler_if #(.NUM_ENG(4), .ITER_W(8)) f_if ();

    mandel_pixel_scheduler #(.NUM_ENG(4)) dut_full (
        .clk(clk), .rst(rst), .start(f_start), .xmin(f_xmin), .ymax(f_ymax), .dx(f_dx),
        .dy(f_dy), .done(f_done), .eng(f_if), .vga_x(f_vx), .vga_y(f_vy),
        .vga_colour(f_vc), .vga_plot(f_plot)
    );

    // mode 0: engines driven directly by tasks; mode 1: behavioural engine model
    logic        mode = 1'b0;
    logic [3:0]  man_idle = '0, man_valid = '0;
    logic [31:0] man_iter = '0;
    logic [3:0]  m_run = '0, m_valid = '0;
    logic [31:0] m_iter = '0;
    int          m_cnt [4];

    assign f_if.eng_idle      = mode ? (~m_run & ~m_valid) : man_idle;
    assign f_if.eng_res_valid = mode ? m_valid : man_valid;
    assign f_if.eng_res_iter  = mode ? m_iter : man_iter;

    always @(posedge clk) begin
        if (rst) begin
            m_run   <= '0;
            m_valid <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (f_if.eng_start[i]) begin
                    m_run[i]        <= 1'b1;
                    m_cnt[i]        <= int'($urandom_range(8, 1));
                    m_iter[i*8 +: 8] <= 8'($urandom_range(255, 0));
                end else if (m_run[i]) begin
                    if (m_cnt[i] <= 1) begin
                        m_run[i]   <= 1'b0;
                        m_valid[i] <= 1'b1;
                    end else begin
                        m_cnt[i] <= m_cnt[i] - 1;
                    end
                end
                if (f_if.eng_res_ack[i]) m_valid[i] <= 1'b0;
            end
        end
    end

    // Small instance (1 engine, 2x2)
    logic       s_start = 1'b0;
    fixed_t     s_xmin = '0, s_ymax = '0, s_dx = '0, s_dy = '0;
    logic       s_done, s_plot;
    logic [8:0] s_vx;
    logic [7:0] s_vy;
    logic [2:0] s_vc;
    logic       sm_run = 1'b0, sm_valid = 1'b0;
    int         sm_cnt = 0;
    mandel_pixel_scheduler_if #(.NUM_ENG(1), .ITER_W(8)) s_if ();

    mandel_pixel_scheduler #(.NUM_ENG(1), .SCREEN_W(2), .SCREEN_H(2)) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .xmin(s_xmin), .ymax(s_ymax), .dx(s_dx),
        .dy(s_dy), .done(s_done), .eng(s_if), .vga_x(s_vx), .vga_y(s_vy),
        .vga_colour(s_vc), .vga_plot(s_plot)
    );

    assign s_if.eng_idle      = ~sm_run & ~sm_valid;
    assign s_if.eng_res_valid = sm_valid;
    assign s_if.eng_res_iter  = 8'd13;

    always @(posedge clk) begin
        if (rst) begin
            sm_run   <= 1'b0;
            sm_valid <= 1'b0;
        end else begin
            if (s_if.eng_start[0]) begin
                sm_run <= 1'b1;
                sm_cnt <= 2;
            end else if (sm_run) begin
                if (sm_cnt == 1) begin
                    sm_run   <= 1'b0;
                    sm_valid <= 1'b1;
                end else begin
                    sm_cnt <= sm_cnt - 1;
                end
            end
            if (s_if.eng_res_ack[0]) sm_valid <= 1'b0;
        end
    end

    bit seen [160][120];

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mode = 1'b0;
        rst  = 1'b1;
        repeat (2) begin
            f_start   = 1'($urandom);
            f_xmin    = $urandom;
            f_ymax    = $urandom;
            f_dx      = $urandom;
            f_dy      = $urandom;
            man_idle  = 4'($urandom);
            man_valid = 4'($urandom);
            man_iter  = $urandom;
            @(negedge clk);
        end
        #1;
        checks++; if (f_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", f_done); end
        checks++; if (f_plot !== 1'b0) begin failures++; $display("FAIL reset_plot got=%b want=0", f_plot); end
        checks++; if (f_if.eng_start !== 4'h0) begin failures++; $display("FAIL reset_eng_start got=%b want=0000", f_if.eng_start); end
        checks++; if (f_if.eng_res_ack !== 4'h0) begin failures++; $display("FAIL reset_ack got=%b want=0000", f_if.eng_res_ack); end
        checks++; if ({f_vx, f_vy, f_vc} !== 20'h0) begin failures++; $display("FAIL reset_vga got=%h,%h,%h want=0", f_vx, f_vy, f_vc); end
        checks++; if ({f_if.eng_cx, f_if.eng_cy} !== 64'h0) begin failures++; $display("FAIL reset_cxcy got=%h,%h want=0", f_if.eng_cx, f_if.eng_cy); end
        checks++; if (dut_full.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=IDLE", dut_full.state_q); end
        f_start   = 1'b0;
        man_idle  = '0;
        man_valid = '0;
        man_iter  = '0;
        rst       = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_raster();
        fixed_t exp_cx [4] = '{32'hFF800000, 32'hFF900000, 32'hFF800000, 32'hFF900000};
        fixed_t exp_cy [4] = '{32'h00400000, 32'h00400000, 32'h00300000, 32'h00300000};
        int     exp_px [4] = '{0, 1, 0, 1};
        int     exp_py [4] = '{0, 0, 1, 1};
        int     d = 0, p = 0;
        logic   fin = 1'b0;
        do_reset();
        s_xmin  = 32'hFF800000;
        s_ymax  = 32'h00400000;
        s_dx    = 32'h00100000;
        s_dy    = 32'h00100000;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (s_if.eng_start[0]) begin
                if (d < 4) begin
                    checks++;
                    if (s_if.eng_cx !== exp_cx[d] || s_if.eng_cy !== exp_cy[d]) begin
                        failures++;
                        $display("FAIL raster_coord[%0d] got=%h,%h want=%h,%h", d,
                                 s_if.eng_cx, s_if.eng_cy, exp_cx[d], exp_cy[d]);
                    end
                end
                d++;
            end
            if (s_plot) begin
                if (p < 4) begin
                    checks++;
                    if (s_vx !== 9'(exp_px[p]) || s_vy !== 8'(exp_py[p]) || s_vc !== 3'd5) begin
                        failures++;
                        $display("FAIL raster_plot[%0d] got=(%0d,%0d,c%0d) want=(%0d,%0d,c5)", p,
                                 s_vx, s_vy, s_vc, exp_px[p], exp_py[p]);
                    end
                end
                p++;
            end
            if (s_done) begin
                fin = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (fin !== 1'b1) begin failures++; $display("FAIL raster_done got=%b want=1", fin); end
        checks++; if (d != 4) begin failures++; $display("FAIL raster_dispatches got=%0d want=4", d); end
        checks++; if (p != 4) begin failures++; $display("FAIL raster_plots got=%0d want=4", p); end
    endtask

    // Starts a frame and fills all four engines in order 0..3 (tags x=0..3, y=0).
    task automatic prime_full();
        mode      = 1'b0;
        man_idle  = '0;
        man_valid = '0;
        man_iter  = '0;
        f_xmin    = 32'hFF800000;
        f_ymax    = 32'h00400000;
        f_dx      = 32'h00100000;
        f_dy      = 32'h00100000;
        f_start   = 1'b1;
        @(negedge clk);
        f_start  = 1'b0;
        man_idle = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (f_if.eng_start !== 4'(1 << k) || f_if.eng_cx !== f_xmin + 32'(k) * f_dx) begin
                failures++;
                $display("FAIL prime_dispatch[%0d] got=%b,%h want=%b,%h", k, f_if.eng_start,
                         f_if.eng_cx, 4'(1 << k), f_xmin + 32'(k) * f_dx);
            end
            @(negedge clk);
        end
        man_idle = '0;
    endtask

    task automatic test_colour();
        logic [7:0] iters [4] = '{8'd255, 8'd13, 8'd8, 8'd254};
        logic [2:0] cols  [4] = '{3'd0, 3'd5, 3'd0, 3'd6};
        do_reset();
        prime_full();
        for (int k = 0; k < 4; k++) begin
            man_iter[k*8 +: 8] = iters[k];
            man_valid          = 4'(1 << k);
            @(negedge clk);
            #1;
            checks++;
            if (f_plot !== 1'b1 || f_if.eng_res_ack !== 4'(1 << k) || f_vc !== cols[k] ||
                f_vx !== 9'(k) || f_vy !== 8'd0) begin
                failures++;
                $display("FAIL colour[%0d] got=plot%b ack%b c%0d (%0d,%0d) want=plot1 ack%b c%0d (%0d,0)",
                         k, f_plot, f_if.eng_res_ack, f_vc, f_vx, f_vy, 4'(1 << k), cols[k], k);
            end
            man_valid = '0;
        end
        @(negedge clk);
        #1;
        checks++; if (f_plot !== 1'b0) begin failures++; $display("FAIL colour_plot_idle got=%b want=0", f_plot); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [2:0] exp_col [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        do_reset();
        prime_full();
        man_iter  = {8'd4, 8'd3, 8'd2, 8'd1};
        man_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (f_plot !== 1'b1 || f_if.eng_res_ack !== exp_ack[k] || f_vx !== 9'(k) ||
                f_vy !== 8'd0 || f_vc !== exp_col[k]) begin
                failures++;
                $display("FAIL fair_grant[%0d] got=plot%b ack%b (%0d,%0d) c%0d want=plot1 ack%b (%0d,0) c%0d",
                         k, f_plot, f_if.eng_res_ack, f_vx, f_vy, f_vc, exp_ack[k], k, exp_col[k]);
            end
            if (k == 0) man_idle[0] = 1'b1;
            if (k == 1) begin
                checks++;
                if (f_if.eng_start !== 4'b0001 || f_if.eng_cx !== f_xmin + 32'd4 * f_dx) begin
                    failures++;
                    $display("FAIL fair_redispatch got=%b,%h want=0001,%h", f_if.eng_start,
                             f_if.eng_cx, f_xmin + 32'd4 * f_dx);
                end
            end
            if (k == 2) man_idle[0] = 1'b0;
            if (k >= 1 && k <= 3) man_valid[k] = 1'b0;
            if (k == 4) man_valid[0] = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        do_reset();
        mode    = 1'b1;
        f_xmin  = 32'h12345678;
        f_ymax  = 32'h00400000;
        f_dx    = 32'h00001000;
        f_dy    = 32'h00001000;
        f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            #1;
            if (|f_if.eng_start) n++;
            if (n == 37) break;
            @(negedge clk);
        end
        checks++; if (n != 37) begin failures++; $display("FAIL midrst_reach37 got=%0d want=37", n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (dut_full.state_q !== IDLE || f_plot !== 1'b0 || f_if.eng_res_ack !== 4'h0 ||
            f_if.eng_start !== 4'h0) begin
            failures++;
            $display("FAIL midrst_abort got=st%0d plot%b ack%b start%b want=IDLE,0,0000,0000",
                     dut_full.state_q, f_plot, f_if.eng_res_ack, f_if.eng_start);
        end
        f_xmin  = 32'h00ABCDEF;
        f_ymax  = 32'hFFC00000;
        f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
        #1;
        checks++;
        if (f_if.eng_start !== 4'b0001 || f_if.eng_cx !== 32'h00ABCDEF || f_if.eng_cy !== 32'hFFC00000) begin
            failures++;
            $display("FAIL midrst_restart got=%b,%h,%h want=0001,00abcdef,ffc00000",
                     f_if.eng_start, f_if.eng_cx, f_if.eng_cy);
        end
    endtask

    task automatic test_full_frame();
        int   plots = 0, dups = 0;
        logic fin = 1'b0, plot_at_done = 1'b0;
        do_reset();
        for (int i = 0; i < 160; i++) for (int j = 0; j < 120; j++) seen[i][j] = 1'b0;
        mode    = 1'b1;
        f_xmin  = 32'hFF800000;
        f_ymax  = 32'h00400000;
        f_dx    = 32'h00006000;
        f_dy    = 32'h00008000;
        f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            #1;
            if (f_plot) begin
                if (f_vx >= 9'd160 || f_vy >= 8'd120) dups++;
                else if (seen[f_vx][f_vy]) dups++;
                else seen[f_vx][f_vy] = 1'b1;
                plots++;
            end
            if (f_done) begin
                fin          = 1'b1;
                plot_at_done = f_plot;
                break;
            end
            @(negedge clk);
        end
        checks++; if (fin !== 1'b1) begin failures++; $display("FAIL frame_done got=%b want=1", fin); end
        checks++; if (plots != 19200) begin failures++; $display("FAIL frame_plots got=%0d want=19200", plots); end
        checks++; if (dups != 0) begin failures++; $display("FAIL frame_unique got=%0d dups want=0", dups); end
        checks++; if (plot_at_done !== 1'b0) begin failures++; $display("FAIL frame_done_after_plot got=%b want=0", plot_at_done); end
        f_xmin  = 32'h00000000;
        f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
        #1;
        checks++;
        if (f_done !== 1'b0 || dut_full.state_q !== RUN || f_if.eng_start !== 4'b0001 ||
            f_if.eng_cx !== 32'h0) begin
            failures++;
            $display("FAIL frame_restart got=done%b st%0d start%b cx%h want=done0 RUN 0001 0",
                     f_done, dut_full.state_q, f_if.eng_start, f_if.eng_cx);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_raster();
        test_colour();
        test_fairness();
        test_reset_midframe();
        test_full_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
